// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor-width constants and the lowest-set-bit encoder
package elevator_pkg;
    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [FLOOR_W-1:0] lowest_set(input logic [MAX_FLOORS-1:0] bits);
        lowest_set = '0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (bits[i]) lowest_set = FLOOR_W'(i);
        end
    endfunction
endpackage

// File: rtl/floor_fifo.sv
// rtl/floor_fifo.sv - synchronous show-ahead FIFO of floor numbers
module floor_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = FLOOR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [4:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [4:0]       count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == 5'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    // Masked while empty so the head reads 0 rather than stale memory.
    assign dout    = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = next_ptr(wptr_q);
        if (do_pop)  rptr_d = next_ptr(rptr_q);
        if (do_push && !do_pop)      count_d = count_q + 5'd1;
        else if (!do_push && do_pop) count_d = count_q - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/call_request_queue.sv
// rtl/call_request_queue.sv - call-button edge detect, dedup bitmaps and floor queue
module call_request_queue
    import elevator_pkg::*;
#(
    parameter int NFLOORS = 16,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NFLOORS-1:0] call_btn,
    output logic [3:0]         obj,
    output logic               obj_valid,
    input  logic               obj_ready,
    output logic [NFLOORS-1:0] lamp,
    output logic [4:0]         count
);
    logic [NFLOORS-1:0] btn_prev_q;
    logic [NFLOORS-1:0] latched_q, latched_d;
    logic [NFLOORS-1:0] queued_q, queued_d;
    logic [NFLOORS-1:0] press, pop_mask, enq_mask;
    logic [FLOOR_W-1:0] enq_idx;
    logic               fifo_empty, fifo_full, push, pop;

    assign press     = call_btn & ~btn_prev_q;
    assign obj_valid = ~fifo_empty;
    assign pop       = obj_valid & obj_ready;
    assign pop_mask  = pop ? (NFLOORS'(1) << obj) : '0;
    assign enq_idx   = lowest_set(MAX_FLOORS'(latched_q));
    assign push      = (latched_q != '0) & ~fifo_full;
    assign enq_mask  = push ? (NFLOORS'(1) << enq_idx) : '0;
    assign lamp      = latched_q | queued_q;

    // A floor leaving the head this cycle may be requested again immediately.
    always_comb begin
        latched_d = (latched_q & ~enq_mask) | (press & ~latched_q & (~queued_q | pop_mask));
        queued_d  = (queued_q & ~pop_mask) | enq_mask;
    end

    always_ff @(posedge clk) begin
        // Sampled through reset so a button held across it needs a fresh press.
        btn_prev_q <= call_btn;
        if (!rst_n) begin
            latched_q <= '0;
            queued_q  <= '0;
        end else begin
            latched_q <= latched_d;
            queued_q  <= queued_d;
        end
    end

    floor_fifo #(
        .DEPTH (DEPTH),
        .W     (FLOOR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enq_idx),
        .pop   (pop),
        .dout  (obj),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );
endmodule

// File: tb/tb_call_request_queue.sv
// tb/tb_call_request_queue.sv - directed scoreboard bench for call_request_queue
module tb_call_request_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] m_btn;
    logic [3:0]  m_obj;
    logic        m_valid, m_ready;
    logic [15:0] m_lamp;
    logic [4:0]  m_count;
    logic [7:0]  s_btn;
    logic [3:0]  s_obj;
    logic        s_valid, s_ready;
    logic [7:0]  s_lamp;
    logic [4:0]  s_count;

    int tests = 0;
    int fails = 0;
    int sb_m[$];
    int sb_s[$];

    always #5 clk = ~clk;

    call_request_queue #(.NFLOORS(16), .DEPTH(16)) u_main (
        .clk(clk), .rst_n(rst_n), .call_btn(m_btn), .obj(m_obj), .obj_valid(m_valid),
        .obj_ready(m_ready), .lamp(m_lamp), .count(m_count)
    );

    call_request_queue #(.NFLOORS(8), .DEPTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .call_btn(s_btn), .obj(s_obj), .obj_valid(s_valid),
        .obj_ready(s_ready), .lamp(s_lamp), .count(s_count)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are scored mid-cycle, then inputs may change 1 ns after the edge.
    task automatic cyc();
        int e;
        #4;
        if (m_valid && m_ready) begin
            if (sb_m.size() == 0) chk("main_unexpected_pop", int'(m_obj), -1);
            else begin
                e = sb_m.pop_front();
                chk("main_pop_obj", int'(m_obj), e);
            end
        end
        if (s_valid && s_ready) begin
            if (sb_s.size() == 0) chk("small_unexpected_pop", int'(s_obj), -1);
            else begin
                e = sb_s.pop_front();
                chk("small_pop_obj", int'(s_obj), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; m_btn = '0; m_ready = 1'b0; s_btn = '0; s_ready = 1'b0;
        @(posedge clk); #1;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_count", int'(m_count), 0);
        chk("rst_lamp", int'(m_lamp), 0);
        chk("rst_obj", int'(m_obj), 0);

        // Single call on floor 5
        m_btn = 16'h0020; sb_m.push_back(5);
        cyc();
        m_btn = '0;
        chk("single_valid_k", int'(m_valid), 0);
        chk("single_lamp_k", int'(m_lamp), 16'h0020);
        cyc();
        chk("single_valid", int'(m_valid), 1);
        chk("single_obj", int'(m_obj), 5);
        chk("single_count", int'(m_count), 1);
        chk("single_lamp", int'(m_lamp), 16'h0020);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("single_pop_valid", int'(m_valid), 0);
        chk("single_pop_lamp", int'(m_lamp), 0);
        chk("single_pop_count", int'(m_count), 0);

        // Simultaneous calls 7, 2, 9 leave in ascending order back to back
        m_ready = 1'b1;
        m_btn = 16'h0284; sb_m.push_back(2); sb_m.push_back(7); sb_m.push_back(9);
        cyc();
        m_btn = '0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("simul_valid_cont", int'(m_valid), 1);
            cyc();
        end
        m_ready = 1'b0;
        chk("simul_drained_valid", int'(m_valid), 0);
        chk("simul_sb_empty", sb_m.size(), 0);

        // Dedup: floor 3 re-pressed while queued, floor 4 held
        m_btn = 16'h0018; sb_m.push_back(3); sb_m.push_back(4);
        cyc();
        m_btn = 16'h0010;
        cyc();
        m_btn = 16'h0018;
        for (int i = 0; i < 8; i++) cyc();
        m_btn = '0;
        cyc(); cyc();
        chk("dedup_count", int'(m_count), 2);
        chk("dedup_lamp", int'(m_lamp), 16'h0018);
        m_ready = 1'b1;
        cyc(); cyc();
        m_ready = 1'b0;
        chk("dedup_drained", int'(m_count), 0);
        chk("dedup_sb_empty", sb_m.size(), 0);

        // Re-press floor 6 in the cycle it is popped
        m_btn = 16'h0040; sb_m.push_back(6);
        cyc();
        m_btn = '0;
        cyc();
        chk("repress_head", int'(m_obj), 6);
        m_btn = 16'h0040; m_ready = 1'b1; sb_m.push_back(6);
        cyc();
        m_btn = '0; m_ready = 1'b0;
        chk("repress_gap_valid", int'(m_valid), 0);
        chk("repress_latched_lamp", int'(m_lamp), 16'h0040);
        cyc();
        chk("repress_valid", int'(m_valid), 1);
        chk("repress_obj", int'(m_obj), 6);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("repress_sb_empty", sb_m.size(), 0);

        // Full FIFO on the DEPTH=2 instance
        s_btn = 8'h1E;
        for (int f = 1; f <= 4; f++) sb_s.push_back(f);
        cyc();
        s_btn = '0;
        for (int i = 0; i < 4; i++) cyc();
        chk("full_count", int'(s_count), 2);
        chk("full_lamp", int'(s_lamp[4:1]), 4'hF);
        chk("full_head", int'(s_obj), 1);
        s_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        s_ready = 1'b0;
        chk("full_sb_empty", sb_s.size(), 0);
        chk("full_drained", int'(s_count), 0);

        // Reset with 3 queued and 2 latched, buttons held through it
        m_btn = 16'h0C0E;
        cyc(); cyc(); cyc(); cyc();
        chk("midrst_pre_count", int'(m_count), 3);
        chk("midrst_pre_lamp", int'(m_lamp), 16'h0C0E);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_valid", int'(m_valid), 0);
        chk("midrst_count", int'(m_count), 0);
        chk("midrst_lamp", int'(m_lamp), 0);
        cyc(); cyc(); cyc();
        chk("midrst_held_count", int'(m_count), 0);
        chk("midrst_held_lamp", int'(m_lamp), 0);
        m_btn = '0;
        cyc();
        m_btn = 16'h0400; sb_m.push_back(10);
        cyc();
        m_btn = '0;
        cyc();
        chk("midrst_repress_obj", int'(m_obj), 10);
        chk("midrst_repress_valid", int'(m_valid), 1);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("final_sb_empty", sb_m.size(), 0);
        chk("final_count", int'(m_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
